uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single byte-wide UART transmit channel (output_en/output_data/output_busy) among N_REQ
//  byte-stream producers (puzzle result printer, error reporter, echo, ...). Round-robin, message-atomic:
//  a granted requester keeps the channel until it sends a byte flagged last (or times out).
//  Sits between the puzzle/diagnostic blocks and the UART transmitter.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  TIMEOUT  1024  idle cycles (granted requester, no valid byte) before forced release; 0 = disabled
// PORTS
//  clk          in   1         system clock; one clock domain
//  rst          in   1         synchronous, active-high reset
//  req_valid    in   N_REQ     requester i has a byte on req_data[8*i+:8]
//  req_data     in   8*N_REQ   byte from requester i
//  req_last     in   N_REQ     byte from requester i ends its message
//  req_ready    out  N_REQ     byte from requester i accepted this cycle when valid&ready
//  output_busy  in   1         UART transmitter busy; byte not taken while high
//  output_en    out  1         output_data valid; held until taken
//  output_data  out  8         byte to transmit
//  grant_id     out  3         index of current owner (valid when grant_active)
//  grant_active out  1         a message is in progress
//  timeout_evt  out  1         one-cycle pulse on forced release
// BEHAVIOUR
//  Reset (all on the cycle after rst high): state IDLE, output_en=0, output_data=0, req_ready=0,
//   grant_id=0, grant_active=0, timeout_evt=0, rr pointer=0, idle counter=0; buffered byte discarded.
//  Output register: one byte (out_valid,out_data); output_en=out_valid. Byte taken in any cycle with
//   output_en=1 and output_busy=0. output_en/output_data stay stable until taken.
//  req_ready[i] = (state==STREAM) & (grant_id==i) & (!out_valid | !output_busy); combinational;
//   all other bits 0. Accepted byte lands in output register next cycle (no drop, no duplicate).
//  IDLE: scan req_valid from rr pointer upward, wrapping mod N_REQ; first set bit i -> next cycle
//   STREAM, grant_id=i, grant_active=1. No request -> stay IDLE. Arbitration costs 1 cycle;
//   first byte appears on output_en 2 cycles after req_valid rises (output free).
//  STREAM: on accept with req_last[grant_id]=1 -> IDLE next cycle, rr pointer=(grant_id+1) mod N_REQ,
//   grant_active=0. The last byte may still be in the output register; it is sent normally, and
//   the next owner's bytes queue behind it.
//  Timeout (TIMEOUT>0): counter cleared on grant and on every accept; increments each STREAM cycle
//   with req_valid[grant_id]=0; on reaching TIMEOUT -> timeout_evt=1 for one cycle, IDLE,
//   rr pointer advances as for last. Cycles stalled by output_busy with valid high do not count.
//  req_valid of non-owners ignored during STREAM; requesters must hold valid/data/last until ready.
//  Bytes never altered; per-requester order preserved; messages never interleaved.
//  rst mid-message: message truncated; requester must restart its message after reset.
// TESTING
//  1 Req0 sends "12\n" (last on 0x0A), busy=0 -> output_en high 3 consecutive cycles carrying
//    0x31,0x32,0x0A, first 2 cycles after req_valid rose; grant_active falls after last accept.
//  2 Req0 and req1 raise valid same cycle, 3-byte msgs each -> all req0 bytes out before any req1;
//    then req0 and req1 contend again -> req1 granted (rr pointer=1).
//  3 Busy high 5 cycles mid-message -> output_en=1, output_data constant, req_ready=0 throughout;
//    after busy drops stream resumes, byte count out == in.
//  4 TIMEOUT=16: req0 sends 0x41 without last then drops valid; req1 valid -> timeout_evt pulse
//    exactly 16 cycles after 0x41 accept; req1 granted next; 0x41 still transmitted once.
//  5 rst high for 1 cycle mid-message (output_en=1) -> next cycle output_en=0, req_ready=0,
//    grant_active=0; next request scan starts at req0.
//  6 All 4 requesters continuously valid with 1-byte last messages 0x30+i -> output sequence
//    0x30,0x31,0x32,0x33,0x30,... no requester skipped.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one byte-wide UART
// transmit channel among N_REQ producers, with forced release of an idle owner.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               output_busy,
  output logic               output_en,
  output logic [7:0]         output_data,
  output logic [2:0]         grant_id,
  output logic               grant_active,
  output logic               timeout_evt
);

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t        state_r;
  logic [2:0]    grant_id_r;
  logic [2:0]    rr_ptr_r;
  logic          grant_active_r;
  logic          out_valid_r;
  logic [7:0]    out_data_r;
  logic [CW-1:0] idle_cnt_r;
  logic          timeout_evt_r;

  logic          slot_open_s;
  logic          accept_s;
  logic          take_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic [7:0]    sel_data_s;
  logic          found_s;
  logic [2:0]    pick_s;
  logic [3:0]    best_d_s;
  logic [3:0]    dist_s;
  logic          hit_s;
  logic [2:0]    next_ptr_s;

  // The output register can take a byte when empty or when it is being emptied this cycle.
  assign slot_open_s = (state_r == STREAM) && (!out_valid_r || !output_busy);
  assign accept_s    = slot_open_s && sel_valid_s;
  assign take_s      = out_valid_r && !output_busy;
  assign next_ptr_s  = (grant_id_r == 3'(N_REQ - 1)) ? 3'd0 : grant_id_r + 3'd1;

  assign output_en    = out_valid_r;
  assign output_data  = out_data_r;
  assign grant_id     = grant_id_r;
  assign grant_active = grant_active_r;
  assign timeout_evt  = timeout_evt_r;

  // Owner handshake steering and round-robin pick (smallest distance from rr pointer).
  always_comb begin
    req_ready   = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    found_s     = 1'b0;
    pick_s      = 3'd0;
    best_d_s    = 4'hF;
    dist_s      = 4'h0;
    hit_s       = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = slot_open_s && (grant_id_r == 3'(i));
      sel_valid_s  = sel_valid_s | (req_valid[i] & (grant_id_r == 3'(i)));
      sel_last_s   = sel_last_s | (req_last[i] & (grant_id_r == 3'(i)));
      sel_data_s   = sel_data_s | (req_data[8*i +: 8] & {8{grant_id_r == 3'(i)}});
      dist_s       = (4'(i) >= {1'b0, rr_ptr_r}) ? (4'(i) - {1'b0, rr_ptr_r})
                                                 : (4'(i) + 4'(N_REQ) - {1'b0, rr_ptr_r});
      hit_s        = req_valid[i] && (dist_s < best_d_s);
      pick_s       = hit_s ? 3'(i) : pick_s;
      best_d_s     = hit_s ? dist_s : best_d_s;
      found_s      = found_s | req_valid[i];
    end
  end

  // Arbitration FSM, output byte register and idle-owner timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      grant_id_r     <= 3'd0;
      rr_ptr_r       <= 3'd0;
      grant_active_r <= 1'b0;
      out_valid_r    <= 1'b0;
      out_data_r     <= 8'h00;
      idle_cnt_r     <= '0;
      timeout_evt_r  <= 1'b0;
    end else begin
      timeout_evt_r <= 1'b0;
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
      end else if (take_s) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r        <= STREAM;
            grant_id_r     <= pick_s;
            grant_active_r <= 1'b1;
            idle_cnt_r     <= '0;
          end
        end
        STREAM: begin
          if (accept_s) begin
            idle_cnt_r <= '0;
            if (sel_last_s) begin
              state_r        <= IDLE;
              grant_active_r <= 1'b0;
              rr_ptr_r       <= next_ptr_s;
            end
          end else if (TO_EN && !sel_valid_s) begin
            // A stall on output_busy keeps valid high, so it never reaches this count.
            if (idle_cnt_r == TO_LAST) begin
              timeout_evt_r  <= 1'b1;
              state_r        <= IDLE;
              grant_active_r <= 1'b0;
              rr_ptr_r       <= next_ptr_s;
              idle_cnt_r     <= '0;
            end else begin
              idle_cnt_r <= idle_cnt_r + CW'(1);
            end
          end
        end
        default: begin
          state_r        <= IDLE;
          grant_active_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte sources, expected
// output byte queue checked by a monitor, plus directed timing checks.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           output_busy = 1'b0;
  logic           output_en;
  logic [7:0]     output_data;
  logic [2:0]     grant_id;
  logic           grant_active;
  logic           timeout_evt;

  int checks = 0;
  int failures = 0;

  logic [8:0] src_q [N][$];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .output_busy(output_busy), .output_en(output_en), .output_data(output_data),
    .grant_id(grant_id), .grant_active(grant_active), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int id, input logic [7:0] b, input logic l);
    src_q[id].push_back({l, b});
  endtask

  task automatic expb(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic do_reset();
    tick(1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0 || output_en || grant_active) && n < 300) begin
      tick(1);
      n++;
    end
    chk({name, "_exp_left"}, exp_q.size(), 0);
    chk({name, "_src_left"}, pending(), 0);
    chk({name, "_idle"}, {output_en, grant_active}, 2'b00);
  endtask

  // Requester model: hold valid/data/last until the byte is accepted.
  initial begin : producer
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_last[i]        = src_q[i][0][8];
          req_data[8*i +: 8] = src_q[i][0][7:0];
        end else begin
          req_valid[i]       = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Monitor: every byte the UART takes must be the next expected one.
  always @(negedge clk) begin
    if (!rst && output_en && !output_busy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_byte: got=0x%02h expected=none", output_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (output_data !== exp_b) begin
          failures++;
          $display("FAIL out_byte: got=0x%02h expected=0x%02h", output_data, exp_b);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    @(negedge clk);
    chk("rst_output_en", output_en, 0);
    chk("rst_output_data", output_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_timeout_evt", timeout_evt, 0);
    tick(1);
    rst = 1'b0;

    // 1: "12\n" from req0, first byte two cycles after valid rises
    tick(1);
    load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b0); load(0, 8'h0A, 1'b1);
    expb(8'h31); expb(8'h32); expb(8'h0A);
    @(negedge clk);
    chk("t1_c0_en", output_en, 0);
    chk("t1_c0_active", grant_active, 0);
    @(negedge clk);
    chk("t1_c1_active", grant_active, 1);
    chk("t1_c1_grant_id", grant_id, 0);
    chk("t1_c1_ready", req_ready, 4'b0001);
    chk("t1_c1_en", output_en, 0);
    @(negedge clk);
    chk("t1_c2_en", output_en, 1);
    chk("t1_c2_active", grant_active, 1);
    @(negedge clk);
    chk("t1_c3_en", output_en, 1);
    @(negedge clk);
    chk("t1_c4_en", output_en, 1);
    chk("t1_c4_active", grant_active, 0);
    @(negedge clk);
    chk("t1_c5_en", output_en, 0);
    drain("t1");

    // 2: req0 and req1 together; req0 has a second message to contend with req1
    do_reset();
    load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
    load(0, 8'h44, 1'b0); load(0, 8'h45, 1'b1);
    load(1, 8'h61, 1'b0); load(1, 8'h62, 1'b0); load(1, 8'h63, 1'b1);
    expb(8'h41); expb(8'h42); expb(8'h43);
    expb(8'h61); expb(8'h62); expb(8'h63);
    expb(8'h44); expb(8'h45);
    repeat (2) @(negedge clk);
    chk("t2_first_grant", grant_id, 0);
    repeat (4) @(negedge clk);
    chk("t2_second_grant", grant_id, 1);
    chk("t2_second_active", grant_active, 1);
    drain("t2");

    // 3: output_busy high for 5 cycles while 0x52 waits in the output register
    tick(1);
    for (int k = 0; k < 5; k++) load(2, 8'h51 + 8'(k), k == 4);
    for (int k = 0; k < 5; k++) expb(8'h51 + 8'(k));
    tick(3);
    output_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_busy_en", output_en, 1);
      chk("t3_busy_data", output_data, 8'h52);
      chk("t3_busy_ready", req_ready, 0);
    end
    tick(1);
    output_busy = 1'b0;
    drain("t3");

    // 4: req0 stalls after 0x41; pulse rises on the 16th edge after the accepting edge
    tick(1);
    load(0, 8'h41, 1'b0);
    load(1, 8'h71, 1'b1);
    expb(8'h41); expb(8'h71);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("t4_evt_c%0d", k), timeout_evt, (k == 18) ? 1 : 0);
      if (k == 18) chk("t4_released", grant_active, 0);
    end
    chk("t4_next_grant", grant_id, 1);
    chk("t4_next_active", grant_active, 1);
    drain("t4");

    // 5: reset while a byte of req3 sits in the output register
    tick(1);
    output_busy = 1'b1;
    for (int k = 0; k < 5; k++) load(3, 8'h81 + 8'(k), k == 4);
    tick(2);
    rst = 1'b1;
    src_q[3].delete();
    @(negedge clk);
    chk("t5_pre_en", output_en, 1);
    tick(1);
    rst = 1'b0;
    output_busy = 1'b0;
    @(negedge clk);
    chk("t5_en", output_en, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_active", grant_active, 0);
    tick(1);
    load(2, 8'h92, 1'b1);
    load(0, 8'h90, 1'b1);
    expb(8'h90); expb(8'h92);
    repeat (2) @(negedge clk);
    chk("t5_scan_from_0", grant_id, 0);
    drain("t5");

    // 6: everyone always valid with one-byte messages
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        load(i, 8'h30 + 8'(i), 1'b1);
        expb(8'h30 + 8'(i));
      end
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
